// File: rtl/pong_game_ctrl.sv
// -----------------------------------------------------------------------------
// pong_game_ctrl
//
// Game sequencer for a two-player Pong. It decides when the ball may move,
// when it is recentred, which way the next serve goes, and keeps both scores.
//
// State flow:
//   IDLE --start level--> SERVE --SERVE_FRAMES ticks--> PLAY --miss--> POINT
//   POINT --no winner--> SERVE
//   POINT --winner-----> OVER --start rising edge--> SERVE
//
// Optional feature macro: PONG_SCORE_LIMIT_EN
//   defined   : reaching WIN_SCORE ends the game in OVER
//   undefined : endless game, scores wrap 9 -> 0, OVER is never entered and
//               o_Game_Over / o_Winner stay 0
//
// Parameters:
//   SERVE_FRAMES  frame ticks spent in SERVE before release (1..255)
//   WIN_SCORE     score that ends the game (1..9)
//
// Ports:
//   i_Clk          system clock, rising edge
//   i_Rst_L        asynchronous active-low reset
//   i_VSync        vertical sync (i_Clk domain); each 0->1 is one frame tick
//   i_Game_Start   start / restart request
//   i_P1_Miss      1-cycle pulse, ball passed player 1's edge
//   i_P2_Miss      1-cycle pulse, ball passed player 2's edge
//   o_Ball_Enable  ball motion allowed (PLAY only)
//   o_Ball_Reset   1-cycle pulse recentring the ball
//   o_Serve_Dir    0 = serve toward P1, 1 = serve toward P2
//   o_P1_Score     player 1 score, 0..9
//   o_P2_Score     player 2 score, 0..9
//   o_State        current FSM state encoding (debug visibility)
//   o_Game_Over    high while in OVER
//   o_Winner       0 = P1 won, 1 = P2 won; meaningful only with o_Game_Over
// -----------------------------------------------------------------------------
module pong_game_ctrl #(
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_VSync,
  input  logic       i_Game_Start,
  input  logic       i_P1_Miss,
  input  logic       i_P2_Miss,
  output logic       o_Ball_Enable,
  output logic       o_Ball_Reset,
  output logic       o_Serve_Dir,
  output logic [3:0] o_P1_Score,
  output logic [3:0] o_P2_Score,
  output logic [2:0] o_State,
  output logic       o_Game_Over,
  output logic       o_Winner
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES);
  localparam logic [3:0] WIN        = 4'(WIN_SCORE);

  state_t     state, state_nxt;
  logic       vsync_q;
  logic       start_q;
  logic       frame_tick;
  logic       start_rise;
  logic [7:0] frame_cnt, frame_cnt_nxt;
  logic [7:0] frame_cnt_inc;
  logic [3:0] p1_score, p1_score_nxt;
  logic [3:0] p2_score, p2_score_nxt;
  logic       serve_dir, serve_dir_nxt;
  logic       ball_reset, ball_reset_nxt;
  logic       game_over;

  // Decimal score counter: 9 rolls over to 0.
  function automatic logic [3:0] score_inc(input logic [3:0] s);
    return (s == 4'd9) ? 4'd0 : s + 4'd1;
  endfunction

  // History registers reset high so a line already high when reset lifts
  // is not mistaken for a fresh rising edge.
  assign frame_tick    = i_VSync & ~vsync_q;
  assign start_rise    = i_Game_Start & ~start_q;
  assign frame_cnt_inc = frame_cnt + 8'd1;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state      <= ST_IDLE;
      vsync_q    <= 1'b1;
      start_q    <= 1'b1;
      frame_cnt  <= 8'd0;
      p1_score   <= 4'd0;
      p2_score   <= 4'd0;
      serve_dir  <= 1'b0;
      ball_reset <= 1'b0;
    end else begin
      state      <= state_nxt;
      vsync_q    <= i_VSync;
      start_q    <= i_Game_Start;
      frame_cnt  <= frame_cnt_nxt;
      p1_score   <= p1_score_nxt;
      p2_score   <= p2_score_nxt;
      serve_dir  <= serve_dir_nxt;
      ball_reset <= ball_reset_nxt;
    end
  end

  // Next-state and datapath updates. o_Ball_Reset is registered, so the
  // recentre pulse coincides with the first cycle of SERVE. Every path
  // into SERVE passes through at least one other state, so the pulse can
  // never be two cycles long.
  always_comb begin
    state_nxt      = state;
    frame_cnt_nxt  = frame_cnt;
    p1_score_nxt   = p1_score;
    p2_score_nxt   = p2_score;
    serve_dir_nxt  = serve_dir;
    ball_reset_nxt = 1'b0;

    case (state)
      ST_IDLE: begin
        if (i_Game_Start) begin
          p1_score_nxt   = 4'd0;
          p2_score_nxt   = 4'd0;
          frame_cnt_nxt  = 8'd0;
          ball_reset_nxt = 1'b1;
          state_nxt      = ST_SERVE;
        end
      end

      ST_SERVE: begin
        if (frame_tick) begin
          frame_cnt_nxt = frame_cnt_inc;
          if (frame_cnt_inc == SERVE_LAST) begin
            state_nxt = ST_PLAY;
          end
        end
      end

      ST_PLAY: begin
        if (i_P1_Miss && !i_P2_Miss) begin
          p2_score_nxt  = score_inc(p2_score);
          serve_dir_nxt = 1'b0;
          state_nxt     = ST_POINT;
        end else if (i_P2_Miss && !i_P1_Miss) begin
          p1_score_nxt  = score_inc(p1_score);
          serve_dir_nxt = 1'b1;
          state_nxt     = ST_POINT;
        end else if (i_P1_Miss && i_P2_Miss) begin
          // Simultaneous miss: nobody scores, the serve is replayed.
          state_nxt = ST_POINT;
        end
      end

      ST_POINT: begin
`ifdef PONG_SCORE_LIMIT_EN
        if ((p1_score == WIN) || (p2_score == WIN)) begin
          state_nxt = ST_OVER;
        end else begin
          frame_cnt_nxt  = 8'd0;
          ball_reset_nxt = 1'b1;
          state_nxt      = ST_SERVE;
        end
`else
        frame_cnt_nxt  = 8'd0;
        ball_reset_nxt = 1'b1;
        state_nxt      = ST_SERVE;
`endif
      end

      ST_OVER: begin
        // Only a fresh press restarts; a button held since the winning
        // point is ignored.
        if (start_rise) begin
          p1_score_nxt   = 4'd0;
          p2_score_nxt   = 4'd0;
          frame_cnt_nxt  = 8'd0;
          ball_reset_nxt = 1'b1;
          state_nxt      = ST_SERVE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

`ifdef PONG_SCORE_LIMIT_EN
  assign game_over = (state == ST_OVER);
`else
  assign game_over = 1'b0;
`endif

  assign o_Ball_Enable = (state == ST_PLAY);
  assign o_Ball_Reset  = ball_reset;
  assign o_Serve_Dir   = serve_dir;
  assign o_P1_Score    = p1_score;
  assign o_P2_Score    = p2_score;
  assign o_State       = state;
  assign o_Game_Over   = game_over;
  // In OVER exactly one side holds WIN_SCORE, so checking P2 is enough.
  assign o_Winner      = game_over & (p2_score == WIN);

endmodule

// File: tb/tb_pong_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pong_game_ctrl
//
// Bench for pong_game_ctrl with SERVE_FRAMES=2, WIN_SCORE=3. Inputs change on
// the falling edge; outputs are sampled 1 ns after the rising edge. Expected
// output words are packed as
//   {ball_enable, ball_reset, serve_dir, p1[3:0], p2[3:0], state[2:0],
//    game_over, winner}
// State encodings: IDLE=0 SERVE=1 PLAY=2 POINT=3 OVER=4.
// -----------------------------------------------------------------------------
module tb_pong_game_ctrl;

  logic       clk;
  logic       rst_n;
  logic       vsync;
  logic       game_start;
  logic       p1_miss;
  logic       p2_miss;
  logic       ball_enable;
  logic       ball_reset;
  logic       serve_dir;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [2:0] state;
  logic       game_over;
  logic       winner;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic        vs;
    logic        st;
    logic        m1;
    logic        m2;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[21];

  pong_game_ctrl #(
    .SERVE_FRAMES(2),
    .WIN_SCORE   (3)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_n),
    .i_VSync      (vsync),
    .i_Game_Start (game_start),
    .i_P1_Miss    (p1_miss),
    .i_P2_Miss    (p2_miss),
    .o_Ball_Enable(ball_enable),
    .o_Ball_Reset (ball_reset),
    .o_Serve_Dir  (serve_dir),
    .o_P1_Score   (p1_score),
    .o_P2_Score   (p2_score),
    .o_State      (state),
    .o_Game_Over  (game_over),
    .o_Winner     (winner)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [15:0] e(input logic en, input logic br, input logic dir,
                                    input logic [3:0] p1, input logic [3:0] p2,
                                    input logic [2:0] st, input logic go, input logic win);
    return {en, br, dir, p1, p2, st, go, win};
  endfunction

  function automatic vec_t v(input logic vs, input logic st, input logic m1,
                             input logic m2, input logic [15:0] exp);
    vec_t r;
    r.vs = vs; r.st = st; r.m1 = m1; r.m2 = m2; r.exp = exp;
    return r;
  endfunction

  // Scoreboard: compare the DUT outputs now against the oldest expectation.
  task automatic compare_now(input string tag);
    logic [15:0] got;
    logic [15:0] want;
    got  = {ball_enable, ball_reset, serve_dir, p1_score, p2_score, state, game_over, winner};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h (en=%b br=%b dir=%b p1=%0d p2=%0d st=%0d go=%b win=%b) expected %h",
               tag, got, got[15], got[14], got[13], got[12:9], got[8:5], got[4:2],
               got[1], got[0], want);
    end
  endtask

  // Called at a falling edge; drives inputs, lets one rising edge pass,
  // checks, and returns at the next falling edge.
  task automatic step(input logic vs, input logic st, input logic m1, input logic m2,
                      input logic [15:0] exp, input string tag);
    vsync      = vs;
    game_start = st;
    p1_miss    = m1;
    p2_miss    = m2;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    compare_now(tag);
    @(negedge clk);
  endtask

  // From the first SERVE cycle (previous VSync low): two frame ticks to PLAY.
  task automatic serve_to_play(input logic [3:0] p1, input logic [3:0] p2, input logic dir);
    step(1'b1, 1'b0, 1'b0, 1'b0, e(1'b0, 1'b0, dir, p1, p2, 3'd1, 1'b0, 1'b0), "serve_tick1");
    step(1'b0, 1'b0, 1'b0, 1'b0, e(1'b0, 1'b0, dir, p1, p2, 3'd1, 1'b0, 1'b0), "serve_gap");
    step(1'b1, 1'b0, 1'b0, 1'b0, e(1'b1, 1'b0, dir, p1, p2, 3'd2, 1'b0, 1'b0), "serve_tick2");
  endtask

  // Async reset: assert between edges and check outputs before any clock.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(16'h0000);
    compare_now(tag);
    @(negedge clk);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [3:0] p;
    logic [3:0] prev;

    rst_n      = 1'b0;
    vsync      = 1'b0;
    game_start = 1'b1;
    p1_miss    = 1'b0;
    p2_miss    = 1'b0;

    // Scenario 1-3 plus miss-ignored-in-SERVE and start-ignored-in-SERVE.
    vecs[0]  = v(0, 1, 0, 0, e(0, 1, 0, 4'd0, 4'd0, 3'd1, 0, 0));
    vecs[1]  = v(0, 0, 0, 0, e(0, 0, 0, 4'd0, 4'd0, 3'd1, 0, 0));
    vecs[2]  = v(1, 0, 0, 0, e(0, 0, 0, 4'd0, 4'd0, 3'd1, 0, 0));
    vecs[3]  = v(1, 0, 0, 0, e(0, 0, 0, 4'd0, 4'd0, 3'd1, 0, 0));
    vecs[4]  = v(0, 0, 0, 0, e(0, 0, 0, 4'd0, 4'd0, 3'd1, 0, 0));
    vecs[5]  = v(1, 0, 0, 0, e(1, 0, 0, 4'd0, 4'd0, 3'd2, 0, 0));
    vecs[6]  = v(0, 0, 1, 0, e(0, 0, 0, 4'd0, 4'd1, 3'd3, 0, 0));
    vecs[7]  = v(0, 0, 0, 0, e(0, 1, 0, 4'd0, 4'd1, 3'd1, 0, 0));
    vecs[8]  = v(0, 0, 0, 0, e(0, 0, 0, 4'd0, 4'd1, 3'd1, 0, 0));
    vecs[9]  = v(1, 0, 1, 0, e(0, 0, 0, 4'd0, 4'd1, 3'd1, 0, 0));
    vecs[10] = v(0, 0, 0, 1, e(0, 0, 0, 4'd0, 4'd1, 3'd1, 0, 0));
    vecs[11] = v(1, 0, 0, 0, e(1, 0, 0, 4'd0, 4'd1, 3'd2, 0, 0));
    vecs[12] = v(0, 0, 0, 1, e(0, 0, 1, 4'd1, 4'd1, 3'd3, 0, 0));
    vecs[13] = v(0, 0, 0, 0, e(0, 1, 1, 4'd1, 4'd1, 3'd1, 0, 0));
    vecs[14] = v(1, 0, 0, 0, e(0, 0, 1, 4'd1, 4'd1, 3'd1, 0, 0));
    vecs[15] = v(0, 0, 0, 0, e(0, 0, 1, 4'd1, 4'd1, 3'd1, 0, 0));
    vecs[16] = v(1, 0, 0, 0, e(1, 0, 1, 4'd1, 4'd1, 3'd2, 0, 0));
    vecs[17] = v(0, 0, 1, 1, e(0, 0, 1, 4'd1, 4'd1, 3'd3, 0, 0));
    vecs[18] = v(0, 0, 0, 0, e(0, 1, 1, 4'd1, 4'd1, 3'd1, 0, 0));
    vecs[19] = v(0, 1, 0, 0, e(0, 0, 1, 4'd1, 4'd1, 3'd1, 0, 0));
    vecs[20] = v(0, 0, 0, 0, e(0, 0, 1, 4'd1, 4'd1, 3'd1, 0, 0));

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(16'h0000);
    compare_now("reset_state");
    @(negedge clk);

    // Release reset with start held high, then run the table.
    rst_n = 1'b1;
    for (int i = 0; i < 21; i++) begin
      step(vecs[i].vs, vecs[i].st, vecs[i].m1, vecs[i].m2, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Reset mid-SERVE with scores 1:1 aborts everything; restart from IDLE.
    async_reset("rst_mid_serve_async");
    step(0, 0, 0, 0, 16'h0000, "in_reset");
    rst_n = 1'b1;
    step(0, 1, 0, 0, e(0, 1, 0, 4'd0, 4'd0, 3'd1, 0, 0), "restart_after_reset");

`ifdef PONG_SCORE_LIMIT_EN
    // Scenario 4: P1 reaches WIN_SCORE=3; start held high across OVER.
    for (int k = 1; k <= 3; k++) begin
      p    = 4'(k);
      prev = 4'(k - 1);
      serve_to_play(prev, 4'd0, (k == 1) ? 1'b0 : 1'b1);
      if (k < 3) begin
        step(0, 0, 0, 1, e(0, 0, 1, p, 4'd0, 3'd3, 0, 0), "p2_miss");
        step(0, 0, 0, 0, e(0, 1, 1, p, 4'd0, 3'd1, 0, 0), "point_to_serve");
      end else begin
        step(0, 1, 0, 1, e(0, 0, 1, p, 4'd0, 3'd3, 0, 0), "p2_miss_win");
        step(0, 1, 0, 0, e(0, 0, 1, 4'd3, 4'd0, 3'd4, 1, 0), "enter_over");
      end
    end
    repeat (3) step(0, 1, 0, 0, e(0, 0, 1, 4'd3, 4'd0, 3'd4, 1, 0), "over_start_held");
    step(1, 1, 1, 1, e(0, 0, 1, 4'd3, 4'd0, 3'd4, 1, 0), "over_ignore_miss");
    step(0, 0, 0, 0, e(0, 0, 1, 4'd3, 4'd0, 3'd4, 1, 0), "over_start_low");
    step(0, 1, 0, 0, e(0, 1, 1, 4'd0, 4'd0, 3'd1, 0, 0), "over_restart");
`else
    // Scenario 5: ten P2 misses, P1 score counts 1..9 then wraps to 0.
    for (int k = 1; k <= 10; k++) begin
      p    = (k == 10) ? 4'd0 : 4'(k);
      prev = 4'(k - 1);
      serve_to_play(prev, 4'd0, (k == 1) ? 1'b0 : 1'b1);
      step(0, 0, 0, 1, e(0, 0, 1, p, 4'd0, 3'd3, 0, 0), "p2_miss_wrap");
      step(0, 0, 0, 0, e(0, 1, 1, p, 4'd0, 3'd1, 0, 0), "point_no_over");
    end
`endif

    // Scenario 6: bring P1 to 2, reset mid-PLAY.
    step(0, 0, 0, 0, e(0, 0, 1, 4'd0, 4'd0, 3'd1, 0, 0), "serve_settle");
    for (int k = 1; k <= 2; k++) begin
      p    = 4'(k);
      prev = 4'(k - 1);
      serve_to_play(prev, 4'd0, 1'b1);
      step(0, 0, 0, 1, e(0, 0, 1, p, 4'd0, 3'd3, 0, 0), "p2_miss_s6");
      step(0, 0, 0, 0, e(0, 1, 1, p, 4'd0, 3'd1, 0, 0), "point_s6");
    end
    serve_to_play(4'd2, 4'd0, 1'b1);
    async_reset("rst_mid_play_async");
    repeat (2) step(0, 1, 0, 0, 16'h0000, "held_reset_no_pulse");
    rst_n = 1'b1;
    step(0, 0, 0, 0, 16'h0000, "idle_after_reset");
    step(0, 1, 0, 0, e(0, 1, 0, 4'd0, 4'd0, 3'd1, 0, 0), "restart_final");
    step(0, 1, 0, 0, e(0, 0, 0, 4'd0, 4'd0, 3'd1, 0, 0), "single_reset_pulse");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 SHALL have parameter SERVE_FRAMES, default 60: frame ticks spent in SERVE before the ball is released (legal range 1..255).
REQ-002 SHALL have parameter WIN_SCORE, default 9: score that ends the game (legal range 1..9).
REQ-003 SHALL have port i_Clk, input, 1 bit: single system clock; all logic is on its rising edge.
REQ-004 SHALL have port i_Rst_L, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port i_VSync, input, 1 bit: VGA vertical sync, synchronous to i_Clk; frame tick source.
REQ-006 SHALL have port i_Game_Start, input, 1 bit: start/restart request.
REQ-007 SHALL have port i_P1_Miss, input, 1 bit: one-cycle pulse; the ball passed player 1's edge.
REQ-008 SHALL have port i_P2_Miss, input, 1 bit: one-cycle pulse; the ball passed player 2's edge.
REQ-009 SHALL have port o_Ball_Enable, output, 1 bit: ball motion allowed.
REQ-010 SHALL have port o_Ball_Reset, output, 1 bit: one-cycle pulse that recentres the ball.
REQ-011 SHALL have port o_Serve_Dir, output, 1 bit: 0 = serve toward P1, 1 = serve toward P2.
REQ-012 SHALL have ports o_P1_Score and o_P2_Score, output, 4 bits each: scores, 0..9.
REQ-013 SHALL have port o_State, output, 3 bits: current state encoding.
REQ-014 SHALL have port o_Game_Over, output, 1 bit: high while in OVER.
REQ-015 SHALL have port o_Winner, output, 1 bit: 0 = P1 won, 1 = P2 won; valid only while o_Game_Over is high.

Function
REQ-016 SHALL generate a one-cycle frame tick on each 0->1 transition of i_VSync, using a single registered copy of i_VSync.
REQ-017 SHALL implement states IDLE=0, SERVE=1, PLAY=2, POINT=3 and OVER=4; all other encodings SHALL go to IDLE on the next cycle.
REQ-018 IDLE: when i_Game_Start=1 (level), SHALL clear both scores, clear the frame counter, pulse o_Ball_Reset, and enter SERVE on the next cycle.
REQ-019 SERVE: SHALL hold o_Ball_Enable=0 and count frame ticks; on the tick that brings the count to SERVE_FRAMES, SHALL enter PLAY in the next cycle.
REQ-020 PLAY: SHALL hold o_Ball_Enable=1 for the whole state.
REQ-021 PLAY with i_P1_Miss only: SHALL increment o_P2_Score, set o_Serve_Dir=0, and enter POINT.
REQ-022 PLAY with i_P2_Miss only: SHALL increment o_P1_Score, set o_Serve_Dir=1, and enter POINT.
REQ-023 PLAY with both miss inputs high in the same cycle: SHALL leave scores and o_Serve_Dir unchanged and enter POINT (replayed serve).
REQ-024 SHALL ignore i_P1_Miss and i_P2_Miss in every state except PLAY.
REQ-025 POINT (exactly one cycle): SHALL drive o_Ball_Enable=0; if either score equals WIN_SCORE, SHALL enter OVER; otherwise SHALL clear the frame counter, pulse o_Ball_Reset, and enter SERVE.
REQ-026 OVER: SHALL hold o_Game_Over=1 and o_Ball_Enable=0, and set o_Winner to the side whose score equals WIN_SCORE.
REQ-027 OVER: SHALL ignore a constantly-high i_Game_Start; only a 0->1 edge on i_Game_Start SHALL clear the scores, pulse o_Ball_Reset, and enter SERVE.
REQ-028 o_Ball_Reset SHALL never be high for two consecutive cycles.

Reset
REQ-029 On i_Rst_L=0, all state SHALL clear immediately: state=IDLE, both scores=0, o_Ball_Enable=0, o_Ball_Reset=0, o_Serve_Dir=0, o_Game_Over=0, o_Winner=0, frame counter=0.
REQ-030 On i_Rst_L=0, the VSync history register SHALL reset to 1 and the i_Game_Start history register SHALL reset to 1, so that no spurious tick or start edge occurs after reset.
REQ-031 Reset asserted mid-SERVE or mid-PLAY SHALL abort the rally with no score change; operation SHALL resume from IDLE.

Configuration
REQ-032 SHALL recognise macro PONG_SCORE_LIMIT_EN.
REQ-033 With PONG_SCORE_LIMIT_EN defined: behaviour SHALL be exactly as REQ-025 to REQ-027.
REQ-034 Without PONG_SCORE_LIMIT_EN: POINT SHALL always go to SERVE; scores SHALL wrap 9->0; OVER, o_Game_Over and o_Winner SHALL be held at 0; WIN_SCORE SHALL be unused.

Verification (SERVE_FRAMES=2, WIN_SCORE=3, macro defined unless stated)
REQ-035 Scenario 1: release reset with i_Game_Start=1 -> one o_Ball_Reset pulse; SERVE; o_Ball_Enable rises the cycle after the 2nd VSync rising edge.
REQ-036 Scenario 2: in PLAY, pulse i_P1_Miss -> o_P2_Score=1, o_Serve_Dir=0, one POINT cycle, then SERVE with one o_Ball_Reset pulse.
REQ-037 Scenario 3: in PLAY, assert i_P1_Miss and i_P2_Miss in the same cycle -> both scores unchanged, POINT then SERVE.
REQ-038 Scenario 4: three i_P2_Miss points -> o_P1_Score=3, o_Game_Over=1, o_Winner=0; with i_Game_Start held high the block stays in OVER; a 0->1 edge clears scores and enters SERVE.
REQ-039 Scenario 5: macro undefined, ten i_P2_Miss points -> o_P1_Score reads 1..9 then 0; o_Game_Over stays 0.
REQ-040 Scenario 6: assert i_Rst_L=0 mid-PLAY with o_P1_Score=2 -> outputs clear asynchronously, before the next clock edge; no o_Ball_Reset pulse during reset.
